// File: rtl/ram512_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram512_fifo_ctrl_if
// Bundles the traffic buses of the FIFO controller: push handshake, pop
// handshake, peek port, occupancy status and the 512x16 RAM access ports.
//
// Signal summary (direction seen from the controller, modport slave):
//   push_valid / push_ready / push_data     : write-side handshake and data
//   pop_valid / pop_ready / pop_data        : read-side handshake, registered head
//   peek_offset / peek_data / peek_hit      : non-destructive read behind the head
//   count / almost_full / max_count         : occupancy status and high watermark
//   ram_wr / ram_wr_addr / ram_d_in         : RAM write port
//   ram_rd_addr_a / ram_d_out_a             : RAM read port A (FIFO head refill)
//   ram_rd_addr_b / ram_d_out_b             : RAM read port B (peek)
// The master modport is the environment view: producer, consumer and RAM.
// ---------------------------------------------------------------------------
interface ram512_fifo_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;

  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;

  logic [AW-1:0] peek_offset;
  logic [DW-1:0] peek_data;
  logic          peek_hit;

  logic [AW:0]   count;
  logic          almost_full;
  logic [AW:0]   max_count;

  logic          ram_wr;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_d_in;
  logic [AW-1:0] ram_rd_addr_a;
  logic [AW-1:0] ram_rd_addr_b;
  logic [DW-1:0] ram_d_out_a;
  logic [DW-1:0] ram_d_out_b;

  modport slave (
    input  push_valid, push_data, pop_ready, peek_offset,
    input  ram_d_out_a, ram_d_out_b,
    output push_ready, pop_valid, pop_data, peek_data, peek_hit,
    output count, almost_full, max_count,
    output ram_wr, ram_wr_addr, ram_d_in, ram_rd_addr_a, ram_rd_addr_b
  );

  modport master (
    output push_valid, push_data, pop_ready, peek_offset,
    output ram_d_out_a, ram_d_out_b,
    input  push_ready, pop_valid, pop_data, peek_data, peek_hit,
    input  count, almost_full, max_count,
    input  ram_wr, ram_wr_addr, ram_d_in, ram_rd_addr_a, ram_rd_addr_b
  );
endinterface

// File: rtl/ram512_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram512_fifo_ctrl
// Circular-buffer FIFO controller wrapped around an external 512x16
// dual-read RAM. The RAM write port and read port A carry FIFO traffic;
// read port B serves random-offset peeks behind the head entry. A registered
// first-word-fall-through stage holds the head entry, so the total occupancy
// can reach DEPTH+1 (RAM full plus output register).
//
// Ports:
//   i_clk    : single clock, all state changes on the rising edge
//   i_reset  : synchronous active-low reset
//   i_flush  : synchronous active-high clear of FIFO contents
//   bus      : ram512_fifo_ctrl_if.slave (push/pop/peek/status/RAM buses)
// ---------------------------------------------------------------------------
module ram512_fifo_ctrl #(
  parameter int AW     = 9,
  parameter int DEPTH  = 512,
  parameter int DW     = 16,
  parameter int AF_LVL = 480
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  ram512_fifo_ctrl_if.slave bus
);

  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_AF_LVL  = (AW+1)'(AF_LVL);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  // State
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_pop_valid;
  logic [DW-1:0] r_pop_data;
  logic [AW:0]   r_max_count;

  // Combinational decode
  logic          w_push_ready;
  logic          w_push_acc;
  logic          w_refill;
  logic          w_drain;
  logic [AW:0]   w_count;
  logic [AW:0]   w_ram_cnt_nxt;

  // Handshake decode: flush suppresses both the write and the head refill.
  always_comb begin
    w_push_ready = i_reset & (r_ram_cnt < C_DEPTH);
    w_push_acc   = bus.push_valid & w_push_ready & ~i_flush;
    // The output register can take a new head when it is empty or being
    // consumed. Requiring ram_cnt > 0 before the edge means the entry read
    // here is never the one being written in the same cycle.
    w_refill     = (~r_pop_valid | bus.pop_ready) & (r_ram_cnt != {(AW+1){1'b0}}) & ~i_flush;
    w_drain      = r_pop_valid & bus.pop_ready & (r_ram_cnt == {(AW+1){1'b0}}) & ~i_flush;
    w_count      = r_ram_cnt + {{AW{1'b0}}, r_pop_valid};
  end

  // Next RAM occupancy: simultaneous push and refill leaves it unchanged.
  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    case ({w_push_acc, w_refill})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + C_CNT_ONE;
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - C_CNT_ONE;
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase
  end

  // Pointer and RAM occupancy registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_ram_cnt <= {(AW+1){1'b0}};
    end else if (i_flush) begin
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_ram_cnt <= {(AW+1){1'b0}};
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;   // rolls 511 -> 0 naturally
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_refill) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_ram_cnt <= w_ram_cnt_nxt;
    end
  end

  // First-word-fall-through output register; pop_data keeps its last value
  // when the stage empties or is flushed.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= {DW{1'b0}};
    end else if (i_flush) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= r_pop_data;
    end else if (w_refill) begin
      r_pop_valid <= 1'b1;
      r_pop_data  <= bus.ram_d_out_a;
    end else if (w_drain) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= r_pop_data;
    end else begin
      r_pop_valid <= r_pop_valid;
      r_pop_data  <= r_pop_data;
    end
  end

  // High watermark of the total occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_max_count <= {(AW+1){1'b0}};
    end else if (i_flush) begin
      r_max_count <= {(AW+1){1'b0}};
    end else if (w_count > r_max_count) begin
      r_max_count <= w_count;
    end else begin
      r_max_count <= r_max_count;
    end
  end

  // Output drive.
  assign bus.push_ready    = w_push_ready;
  assign bus.pop_valid     = r_pop_valid;
  assign bus.pop_data      = r_pop_data;
  assign bus.count         = w_count;
  assign bus.almost_full   = (w_count >= C_AF_LVL);
  assign bus.max_count     = r_max_count;

  assign bus.ram_wr        = w_push_acc;
  assign bus.ram_wr_addr   = r_wr_ptr;
  assign bus.ram_d_in      = bus.push_data;
  assign bus.ram_rd_addr_a = r_rd_ptr;
  // Peek offsets are relative to the entry behind pop_data, i.e. rd_ptr.
  assign bus.ram_rd_addr_b = r_rd_ptr + bus.peek_offset;
  assign bus.peek_data     = bus.ram_d_out_b;
  assign bus.peek_hit      = ({1'b0, bus.peek_offset} < r_ram_cnt);

endmodule

// File: tb/tb_ram512_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram512_fifo_ctrl
// Directed self-checking bench for ram512_fifo_ctrl with a behavioural
// 512x16 dual-read RAM. Inputs change 1 time unit after the rising edge and
// outputs are compared 1 unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_ram512_fifo_ctrl;

  logic clk;
  logic reset;
  logic flush;
  int   n_checks;
  int   n_fail;

  ram512_fifo_ctrl_if #(.AW(9), .DW(16)) bus ();

  ram512_fifo_ctrl #(.AW(9), .DEPTH(512), .DW(16), .AF_LVL(480)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (flush),
    .bus     (bus)
  );

  // Behavioural RAM: synchronous write, combinational reads.
  logic [15:0] mem [0:511];
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_wr_addr] <= bus.ram_d_in;
  end
  assign bus.ram_d_out_a = mem[bus.ram_rd_addr_a];
  assign bus.ram_d_out_b = mem[bus.ram_rd_addr_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush           = 1'b0;
    bus.push_valid  = 1'b0;
    bus.push_data   = 16'h0000;
    bus.pop_ready   = 1'b0;
    bus.peek_offset = 9'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 16'hDEAD;
    #1;
    n_checks++;
    if (bus.push_ready !== 1'b0 || bus.ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_push: push_ready=%0b ram_wr=%0b expected 0 0", bus.push_ready, bus.ram_wr);
    end
    nxt();
    nxt();
    n_checks++;
    if (bus.count !== 10'd0 || bus.pop_valid !== 1'b0 || bus.max_count !== 10'd0 || bus.pop_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d pop_valid=%0b max=%0d pop_data=%h expected 0 0 0 0000",
               bus.count, bus.pop_valid, bus.max_count, bus.pop_data);
    end
    bus.push_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    bus.push_valid = 1'b1;
    bus.push_data  = 16'h1111;
    #1;
    n_checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_wr_addr !== 9'd0 || bus.ram_d_in !== 16'h1111) begin
      n_fail++;
      $display("FAIL single_write: ram_wr=%0b addr=%0d d_in=%h expected 1 0 1111", bus.ram_wr, bus.ram_wr_addr, bus.ram_d_in);
    end
    nxt();
    bus.push_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.pop_valid !== 1'b0 || bus.count !== 10'd1) begin
      n_fail++;
      $display("FAIL single_cycle1: pop_valid=%0b count=%0d expected 0 1", bus.pop_valid, bus.count);
    end
    nxt();
    n_checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h1111 || bus.count !== 10'd1 || bus.max_count !== 10'd1) begin
      n_fail++;
      $display("FAIL single_cycle2: pop_valid=%0b data=%h count=%0d max=%0d expected 1 1111 1 1",
               bus.pop_valid, bus.pop_data, bus.count, bus.max_count);
    end
    bus.pop_ready = 1'b1;
    nxt();
    bus.pop_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.pop_valid !== 1'b0 || bus.count !== 10'd0 || bus.pop_data !== 16'h1111) begin
      n_fail++;
      $display("FAIL single_drain: pop_valid=%0b count=%0d data=%h expected 0 0 1111", bus.pop_valid, bus.count, bus.pop_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i <= 512; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'(i);
      #1;
      n_checks++;
      if (bus.count !== 10'(i) || bus.push_ready !== 1'b1 || bus.almost_full !== (i >= 480)) begin
        n_fail++;
        $display("FAIL fill_step%0d: count=%0d push_ready=%0b af=%0b expected %0d 1 %0b",
                 i, bus.count, bus.push_ready, bus.almost_full, i, (i >= 480));
      end
      nxt();
    end
    bus.push_data = 16'hBEEF;
    #1;
    n_checks++;
    if (bus.push_ready !== 1'b0 || bus.ram_wr !== 1'b0 || bus.count !== 10'd513 || bus.almost_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: push_ready=%0b ram_wr=%0b count=%0d af=%0b expected 0 0 513 1",
               bus.push_ready, bus.ram_wr, bus.count, bus.almost_full);
    end
    bus.push_valid = 1'b0;
    nxt();
    n_checks++;
    if (bus.max_count !== 10'd513) begin
      n_fail++;
      $display("FAIL fill_max_count: got %0d expected 513", bus.max_count);
    end
  endtask

  task automatic test_drain();
    bus.pop_ready = 1'b1;
    for (int i = 0; i <= 512; i++) begin
      #1;
      n_checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'(i)) begin
        n_fail++;
        $display("FAIL drain_entry%0d: pop_valid=%0b data=%0d expected 1 %0d", i, bus.pop_valid, bus.pop_data, i);
      end
      nxt();
    end
    bus.pop_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.pop_valid !== 1'b0 || bus.count !== 10'd0 || bus.push_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: pop_valid=%0b count=%0d push_ready=%0b expected 0 0 1",
               bus.pop_valid, bus.count, bus.push_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.pop_ready = 1'b1;
    for (int c = 0; c <= 1001; c++) begin
      bus.push_valid = (c < 1000);
      bus.push_data  = 16'(c);
      #1;
      if (c < 1000) begin
        n_checks++;
        if (bus.ram_wr !== 1'b1 || bus.ram_wr_addr !== 9'(c)) begin
          n_fail++;
          $display("FAIL stream_write%0d: ram_wr=%0b addr=%0d expected 1 %0d", c, bus.ram_wr, bus.ram_wr_addr, c % 512);
        end
      end
      if (c >= 2) begin
        n_checks++;
        if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'(c - 2)) begin
          n_fail++;
          $display("FAIL stream_read%0d: pop_valid=%0b data=%0d expected 1 %0d", c, bus.pop_valid, bus.pop_data, c - 2);
        end
      end
      nxt();
    end
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b0;
    #1;
    n_checks++;
    if (bus.pop_valid !== 1'b0 || bus.count !== 10'd0 || bus.max_count !== 10'd2) begin
      n_fail++;
      $display("FAIL stream_end: pop_valid=%0b count=%0d max=%0d expected 0 0 2", bus.pop_valid, bus.count, bus.max_count);
    end
  endtask

  task automatic test_peek();
    for (int i = 0; i < 10; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'h00A0 + 16'(i);
      nxt();
    end
    bus.push_valid = 1'b0;
    nxt();
    nxt();
    bus.peek_offset = 9'd3;
    #1;
    n_checks++;
    if (bus.peek_hit !== 1'b1 || bus.peek_data !== 16'h00A4 || bus.pop_data !== 16'h00A0 || bus.ram_rd_addr_b !== 9'd4) begin
      n_fail++;
      $display("FAIL peek_off3: hit=%0b data=%h head=%h addr_b=%0d expected 1 00a4 00a0 4",
               bus.peek_hit, bus.peek_data, bus.pop_data, bus.ram_rd_addr_b);
    end
    bus.peek_offset = 9'd0;
    #1;
    n_checks++;
    if (bus.peek_hit !== 1'b1 || bus.peek_data !== 16'h00A1) begin
      n_fail++;
      $display("FAIL peek_off0: hit=%0b data=%h expected 1 00a1", bus.peek_hit, bus.peek_data);
    end
    bus.peek_offset = 9'd8;
    #1;
    n_checks++;
    if (bus.peek_hit !== 1'b1 || bus.peek_data !== 16'h00A9) begin
      n_fail++;
      $display("FAIL peek_off8: hit=%0b data=%h expected 1 00a9", bus.peek_hit, bus.peek_data);
    end
    bus.peek_offset = 9'd9;
    #1;
    n_checks++;
    if (bus.peek_hit !== 1'b0 || bus.count !== 10'd10) begin
      n_fail++;
      $display("FAIL peek_off9: hit=%0b count=%0d expected 0 10", bus.peek_hit, bus.count);
    end
    bus.peek_offset = 9'd0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'h0050 + 16'(i);
      nxt();
    end
    bus.push_valid = 1'b0;
    nxt();
    n_checks++;
    if (bus.count !== 10'd5) begin
      n_fail++;
      $display("FAIL flush_prefill: count=%0d expected 5", bus.count);
    end
    flush          = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 16'hFFFF;
    bus.pop_ready  = 1'b1;
    #1;
    n_checks++;
    if (bus.ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ram_wr: got %0b expected 0", bus.ram_wr);
    end
    nxt();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.count !== 10'd0 || bus.pop_valid !== 1'b0 || bus.max_count !== 10'd0) begin
      n_fail++;
      $display("FAIL flush_cleared: count=%0d pop_valid=%0b max=%0d expected 0 0 0", bus.count, bus.pop_valid, bus.max_count);
    end
    bus.push_valid = 1'b1;
    bus.push_data  = 16'h0077;
    #1;
    n_checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_wr_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL flush_repush: ram_wr=%0b addr=%0d expected 1 0", bus.ram_wr, bus.ram_wr_addr);
    end
    nxt();
    bus.push_valid = 1'b0;
    nxt();
    n_checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h0077) begin
      n_fail++;
      $display("FAIL flush_refill: pop_valid=%0b data=%h expected 1 0077", bus.pop_valid, bus.pop_data);
    end
  endtask

  task automatic test_reset_midstream();
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'h0100 + 16'(i);
      nxt();
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.push_ready !== 1'b0 || bus.ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_hold: push_ready=%0b ram_wr=%0b expected 0 0", bus.push_ready, bus.ram_wr);
    end
    nxt();
    n_checks++;
    if (bus.count !== 10'd0 || bus.pop_valid !== 1'b0 || bus.max_count !== 10'd0 ||
        bus.pop_data !== 16'h0000 || bus.push_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: count=%0d pop_valid=%0b max=%0d data=%h push_ready=%0b expected 0 0 0 0000 0",
               bus.count, bus.pop_valid, bus.max_count, bus.pop_data, bus.push_ready);
    end
    idle_inputs();
    reset = 1'b1;
    nxt();
    n_checks++;
    if (bus.push_ready !== 1'b1 || bus.count !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_release: push_ready=%0b count=%0d expected 1 0", bus.push_ready, bus.count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    nxt();
    test_reset();
    test_single();
    apply_reset();
    test_fill();
    test_drain();
    apply_reset();
    test_back_to_back();
    apply_reset();
    test_peek();
    apply_reset();
    test_flush();
    apply_reset();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
